mandelbrot_renderer: RTL and testbench
======================================

Name: mandelbrot_renderer

Overview:
Top-level Mandelbrot renderer for the 160x120 VGA adapter framebuffer. After reset it walks every pixel in raster order, iterates z = z^2 + c in fixed point, and issues one plot request per pixel with a 3-bit colour. Raw VGA DAC pins are driven from the current plot colour. LEDR[3] signals frame completion.

Parameters:
MAX_ITER, 8, iteration cap per pixel (1..255)
FRAC, 12, fractional bits of the signed 16-bit Q4.12 format
X_START, -8192, real part of c at x=0, raw Q4.12 (-2.0)
Y_START, -4608, imaginary part of c at y=0, raw Q4.12 (-1.125)
STEP, 77, raw Q4.12 increment per pixel in both axes (~0.0188)

Ports:
CLOCK_50  in   1   system clock
KEY       in   4   KEY[3] is the reset: asynchronous, active-low; KEY[2:0] unused
SW        in   10  unused
LEDR      out  10  LEDR[3]=done, LEDR[0]=busy, others 0
HEX0..HEX5 out 7 each  seven-segment, active-low
VGA_X     out  8   pixel x, 0..159
VGA_Y     out  7   pixel y, 0..119
VGA_COLOUR out 3   pixel colour
VGA_PLOT  out  1   one-cycle write strobe
VGA_R, VGA_G, VGA_B  out 8 each  {8{VGA_COLOUR[2]}}, {8{[1]}}, {8{[0]}}
VGA_HS, VGA_VS  out 1  held 1
VGA_CLK   out  1   equals CLOCK_50

Behaviour:
- Reset (KEY[3]=0, async): state INIT, x=y=0, VGA_X/Y/COLOUR=0, VGA_PLOT=0, LEDR=0, HEX all 7'h7F.
- States: INIT -> ITER -> PLOT -> (INIT | DONE).
- INIT, 1 cycle: cr = X_START + x*STEP, ci = Y_START + y*STEP (16-bit signed). zr=zi=0, iter=0.
- ITER, 1 cycle per step:
  - Compute zr2=(zr*zr)>>>FRAC and zi2=(zi*zi)>>>FRAC. Products are 32-bit signed; the shift is arithmetic.
  - If zr2+zi2 > 4.0 (raw 16384, compared at 33 bits) or iter==MAX_ITER, go to PLOT.
  - Otherwise update both together: zr<=zr2-zi2+cr, zi<=((zr*zi)>>>(FRAC-1))+ci, iter<=iter+1.
- Colour: iter[2:0] if escaped; 0 (black) if iter==MAX_ITER without escape. If escape and cap occur in the same cycle, escape wins.
- PLOT, 1 cycle:
  - VGA_PLOT=1 with VGA_X=x, VGA_Y=y, VGA_COLOUR registered and valid in that cycle. VGA_PLOT is 0 in every other state.
  - Then x++. At x==159, x wraps to 0 and y++.
  - After (159,119), go to DONE; otherwise go to INIT.
- Per-pixel latency: 1 + (iterations+1) + 1 cycles.
- DONE: LEDR[3]=1 and LEDR[0]=0, held until reset; no further plots.
- LEDR[0]=1 in INIT/ITER/PLOT.
- Reset mid-frame aborts immediately. After KEY[3] returns high, the frame restarts at (0,0).
- Overflow safety: the update only occurs while |z|^2 <= 4, so |z'| < 8 and 16-bit Q4.12 never overflows.

Optional Feature:
MANDEL_HEX_STATUS_EN
- Defined: HEX1:HEX0 show y and HEX3:HEX2 show x as hex digits (active-low standard 0-F segment encoding). HEX5:HEX4 show the last plotted colour (HEX5 blank). Values update on every PLOT. All blank (7'h7F) during reset.
- Undefined: all HEX outputs constant 7'h7F and no decoder logic is instantiated.

Test Plan:
- Hold KEY[3]=0 for several clocks -> VGA_PLOT=0, LEDR=0, VGA_X=0, VGA_Y=0 throughout.
- Release reset -> first plot at (0,0) with c=(-8192,-4608): z1=c, then |z|^2 about 5.27 > 4, escape with iter=1 -> VGA_COLOUR=1, VGA_PLOT high exactly one cycle, 4 cycles after INIT entry.
- Pixel (107,60), c=(47,12), inside the set -> reaches MAX_ITER=8 -> VGA_COLOUR=0.
- Count plots until LEDR[3] rises -> exactly 19200 strobes in raster order (x inner, y outer). LEDR[3] rises after the (159,119) plot and stays high with no more strobes.
- Assert KEY[3]=0 mid-frame, then release -> outputs clear asynchronously and the next plot is (0,0) again.
- With MANDEL_HEX_STATUS_EN, plot at (0x12,0x34) -> HEX3/HEX2 show "1","2" and HEX1/HEX0 show "3","4".

Source files
------------

// File: rtl/mandelbrot_renderer.sv
// Mandelbrot renderer: raster-walks the VGA framebuffer, iterates z = z^2 + c in Q4.12 and
// plots one escape-time colour per pixel. Optional HEX status readout: MANDEL_HEX_STATUS_EN.
module mandelbrot_renderer #(
    parameter int unsigned MAX_ITER = 8,
    parameter int unsigned FRAC     = 12,
    parameter int          X_START  = -8192,
    parameter int          Y_START  = -4608,
    parameter int          STEP     = 77,
    parameter int unsigned H_PIXELS = 160,
    parameter int unsigned V_PIXELS = 120
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK
);

    typedef enum logic [1:0] {StInit, StIter, StPlot, StDone} state_e;

    localparam logic [7:0]         ITER_CAP  = 8'(MAX_ITER);
    localparam logic [7:0]         X_LAST    = 8'(H_PIXELS - 1);
    localparam logic [6:0]         Y_LAST    = 7'(V_PIXELS - 1);
    localparam logic signed [32:0] ESC_LIMIT = 33'sd4 <<< FRAC;

    logic rst_n;
    assign rst_n = KEY[3];

    logic unused_inputs;
    assign unused_inputs = ^{SW, KEY[2:0]};

    state_e             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic signed [15:0] cr_q, cr_d, ci_q, ci_d;
    logic signed [15:0] zr_q, zr_d, zi_q, zi_d;
    logic [7:0]         iter_q, iter_d;
    logic [2:0]         colour_q, colour_d;
    logic               plot_q, plot_d;

    // Iteration datapath
    logic signed [31:0] prod_rr, prod_ii, prod_ri;
    logic signed [31:0] zr2, zi2, zr_upd, zi_upd;
    logic signed [31:0] cr_full, ci_full;
    logic signed [32:0] mag2;
    logic               escaped, at_cap;

    always_comb begin
        prod_rr = 32'(zr_q) * 32'(zr_q);
        prod_ii = 32'(zi_q) * 32'(zi_q);
        prod_ri = 32'(zr_q) * 32'(zi_q);
        zr2     = prod_rr >>> FRAC;
        zi2     = prod_ii >>> FRAC;
        mag2    = 33'(zr2) + 33'(zi2);
        escaped = mag2 > ESC_LIMIT;
        at_cap  = iter_q == ITER_CAP;
        zr_upd  = zr2 - zi2 + 32'(cr_q);
        // 2*zr*zi folded into the shift: one bit less of right shift
        zi_upd  = (prod_ri >>> (FRAC - 1)) + 32'(ci_q);
        cr_full = X_START + $signed({24'd0, x_q}) * STEP;
        ci_full = Y_START + $signed({25'd0, y_q}) * STEP;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cr_d     = cr_q;
        ci_d     = ci_q;
        zr_d     = zr_q;
        zi_d     = zi_q;
        iter_d   = iter_q;
        colour_d = colour_q;
        unique case (state_q)
            StInit: begin
                cr_d    = cr_full[15:0];
                ci_d    = ci_full[15:0];
                zr_d    = '0;
                zi_d    = '0;
                iter_d  = '0;
                state_d = StIter;
            end
            StIter: begin
                if (escaped) begin
                    colour_d = iter_q[2:0];
                    state_d  = StPlot;
                end else if (at_cap) begin
                    colour_d = 3'd0;
                    state_d  = StPlot;
                end else begin
                    zr_d   = zr_upd[15:0];
                    zi_d   = zi_upd[15:0];
                    iter_d = iter_q + 8'd1;
                end
            end
            StPlot: begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    x_d     = '0;
                    y_d     = '0;
                    state_d = StDone;
                end else if (x_q == X_LAST) begin
                    x_d     = '0;
                    y_d     = y_q + 7'd1;
                    state_d = StInit;
                end else begin
                    x_d     = x_q + 8'd1;
                    state_d = StInit;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StInit;
            end
        endcase
        plot_d = (state_d == StPlot);
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            x_q      <= '0;
            y_q      <= '0;
            cr_q     <= '0;
            ci_q     <= '0;
            zr_q     <= '0;
            zi_q     <= '0;
            iter_q   <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cr_q     <= cr_d;
            ci_q     <= ci_d;
            zr_q     <= zr_d;
            zi_q     <= zi_d;
            iter_q   <= iter_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    // Busy is gated by the reset pin so LEDR reads 0 while KEY[3] is held low
    assign LEDR       = {6'd0, state_q == StDone, 2'd0, rst_n & (state_q != StDone)};
    assign VGA_X      = x_q;
    assign VGA_Y      = y_q;
    assign VGA_COLOUR = colour_q;
    assign VGA_PLOT   = plot_q;
    assign VGA_R      = {8{colour_q[2]}};
    assign VGA_G      = {8{colour_q[1]}};
    assign VGA_B      = {8{colour_q[0]}};
    assign VGA_HS     = 1'b1;
    assign VGA_VS     = 1'b1;
    assign VGA_CLK    = CLOCK_50;

`ifdef MANDEL_HEX_STATUS_EN
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic       hex_valid_q;
    logic [7:0] hex_x_q;
    logic [6:0] hex_y_q;
    logic [2:0] hex_c_q;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            hex_valid_q <= 1'b0;
            hex_x_q     <= '0;
            hex_y_q     <= '0;
            hex_c_q     <= '0;
        end else if (plot_d) begin
            hex_valid_q <= 1'b1;
            hex_x_q     <= x_q;
            hex_y_q     <= y_q;
            hex_c_q     <= colour_d;
        end
    end

    always_comb begin
        HEX0 = 7'h7F;
        HEX1 = 7'h7F;
        HEX2 = 7'h7F;
        HEX3 = 7'h7F;
        HEX4 = 7'h7F;
        HEX5 = 7'h7F;
        if (hex_valid_q) begin
            HEX0 = seg7(hex_y_q[3:0]);
            HEX1 = seg7({1'b0, hex_y_q[6:4]});
            HEX2 = seg7(hex_x_q[3:0]);
            HEX3 = seg7(hex_x_q[7:4]);
            HEX4 = seg7({1'b0, hex_c_q});
        end
    end
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
`endif

endmodule

// File: tb/tb_mandelbrot_renderer.sv
// Scoreboard bench for mandelbrot_renderer: a full-size instance (reset, raster order, abort)
// and a reduced-frame instance (completion, in-set pixel) checked against an escape-time model.
`timescale 1ns/1ps
module tb_mandelbrot_renderer;

    localparam int FRAC  = 12;
    localparam int STEP  = 77;
    localparam int A_MAX = 8;
    localparam int A_XS  = -8192;
    localparam int A_YS  = -4608;
    localparam int A_W   = 160;
    localparam int A_H   = 120;
    // Window of the full frame around (100,55), so local (7,5) is c = (47,12)
    localparam int B_W   = 16;
    localparam int B_H   = 12;
    localparam int B_XS  = A_XS + 100 * STEP;
    localparam int B_YS  = A_YS + 55 * STEP;

    typedef struct {
        int x;
        int y;
        int colour;
        int lat;
    } pix_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic       rst_a, rst_b;
    logic [2:0] noise = 3'd0;
    logic [9:0] sw = 10'd0;

    logic [9:0] ledr_a, ledr_b;
    logic [6:0] hex_a [6];
    logic [6:0] hex_b [6];
    logic [7:0] x_a, x_b;
    logic [6:0] y_a, y_b;
    logic [2:0] col_a, col_b;
    logic       plot_a, plot_b;
    logic [7:0] r_a, g_a, bl_a, r_b, g_b, bl_b;
    logic       hs_a, vs_a, vclk_a, hs_b, vs_b, vclk_b;

    pix_t qa[$];
    pix_t qb[$];
    int   last_a = 0, last_b = 0;
    int   plots_a = 0, plots_b = 0;
    bit   done_seen_b = 1'b0;

    mandelbrot_renderer dut_a (
        .CLOCK_50(clk), .KEY({rst_a, noise}), .SW(sw), .LEDR(ledr_a),
        .HEX0(hex_a[0]), .HEX1(hex_a[1]), .HEX2(hex_a[2]),
        .HEX3(hex_a[3]), .HEX4(hex_a[4]), .HEX5(hex_a[5]),
        .VGA_X(x_a), .VGA_Y(y_a), .VGA_COLOUR(col_a), .VGA_PLOT(plot_a),
        .VGA_R(r_a), .VGA_G(g_a), .VGA_B(bl_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_CLK(vclk_a)
    );

    mandelbrot_renderer #(
        .X_START(B_XS), .Y_START(B_YS), .H_PIXELS(B_W), .V_PIXELS(B_H)
    ) dut_b (
        .CLOCK_50(clk), .KEY({rst_b, noise}), .SW(sw), .LEDR(ledr_b),
        .HEX0(hex_b[0]), .HEX1(hex_b[1]), .HEX2(hex_b[2]),
        .HEX3(hex_b[3]), .HEX4(hex_b[4]), .HEX5(hex_b[5]),
        .VGA_X(x_b), .VGA_Y(y_b), .VGA_COLOUR(col_b), .VGA_PLOT(plot_b),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(bl_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_CLK(vclk_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int wrap16(input int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    // Escape-time reference: plain integer arithmetic on Q4.12 values
    function automatic void model_pixel(input int xs, input int ys, input int max_iter,
                                        input int x, input int y,
                                        output int colour, output int steps);
        int cr, ci, zr, zi, zr2, zi2, nzr;
        cr = wrap16(xs + x * STEP);
        ci = wrap16(ys + y * STEP);
        zr = 0;
        zi = 0;
        colour = 0;
        steps = 0;
        for (int it = 0; it <= max_iter; it++) begin
            zr2 = (zr * zr) >>> FRAC;
            zi2 = (zi * zi) >>> FRAC;
            if (zr2 + zi2 > (4 << FRAC)) begin
                colour = it % 8;
                steps = it;
                return;
            end
            if (it == max_iter) begin
                colour = 0;
                steps = it;
                return;
            end
            nzr = wrap16(zr2 - zi2 + cr);
            zi  = wrap16(((zr * zi) >>> (FRAC - 1)) + ci);
            zr  = nzr;
        end
    endfunction

    task automatic push_frame(input bit is_b);
        pix_t p;
        int c, s;
        for (int y = 0; y < (is_b ? B_H : A_H); y++) begin
            for (int x = 0; x < (is_b ? B_W : A_W); x++) begin
                model_pixel(is_b ? B_XS : A_XS, is_b ? B_YS : A_YS, A_MAX, x, y, c, s);
                p.x = x;
                p.y = y;
                p.colour = c;
                p.lat = s + 3;
                if (is_b) qb.push_back(p);
                else qa.push_back(p);
            end
        end
    endtask

    function automatic logic [6:0] seg7(input int v);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[v & 15];
    endfunction

    task automatic check_reset(input string tag, input logic plot, input logic [9:0] ledr,
                               input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                               input logic [41:0] hex);
        check({tag, "_rst_plot"}, plot, 0);
        check({tag, "_rst_ledr"}, ledr, 0);
        check({tag, "_rst_xy"}, {x, y}, 0);
        check({tag, "_rst_colour"}, c, 0);
        check({tag, "_rst_hex"}, hex, {6{7'h7F}});
    endtask

    task automatic check_plot(input string tag, input pix_t e, input int gap,
                              input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                              input logic [9:0] ledr, input logic [23:0] rgb,
                              input logic [2:0] sync, input logic [41:0] hex);
        logic [41:0] hex_exp;
        check({tag, "_x"}, x, e.x);
        check({tag, "_y"}, y, e.y);
        check({tag, "_colour"}, c, e.colour);
        check({tag, "_latency"}, gap, e.lat);
        check({tag, "_ledr_busy"}, ledr, 1);
        check({tag, "_dac"}, rgb, {{8{e.colour[2]}}, {8{e.colour[1]}}, {8{e.colour[0]}}});
        check({tag, "_hs_vs_clk"}, sync, 3'b110);
`ifdef MANDEL_HEX_STATUS_EN
        hex_exp = {7'h7F, seg7(e.colour), seg7(e.x >> 4), seg7(e.x), seg7(e.y >> 4), seg7(e.y)};
`else
        hex_exp = {6{7'h7F}};
`endif
        check({tag, "_hex"}, hex, hex_exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        noise = 3'($urandom);
        sw = 10'($urandom);
    end

    // Monitor A
    initial forever begin
        pix_t e;
        @(negedge clk);
        if (!rst_a) begin
            check_reset("a", plot_a, ledr_a, x_a, y_a, col_a,
                        {hex_a[5], hex_a[4], hex_a[3], hex_a[2], hex_a[1], hex_a[0]});
        end else if (plot_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_plot", 1, 0);
            end else begin
                e = qa.pop_front();
                check_plot("a", e, cyc - last_a, x_a, y_a, col_a, ledr_a, {r_a, g_a, bl_a},
                           {hs_a, vs_a, vclk_a},
                           {hex_a[5], hex_a[4], hex_a[3], hex_a[2], hex_a[1], hex_a[0]});
                if (e.x == 0 && e.y == 0) begin
                    check("a_origin_colour", col_a, 1);
                    check("a_origin_latency", cyc - last_a, 4);
                end
            end
            last_a = cyc;
            plots_a++;
        end
    end

    // Monitor B
    initial forever begin
        pix_t e;
        @(negedge clk);
        if (!rst_b) begin
            check_reset("b", plot_b, ledr_b, x_b, y_b, col_b,
                        {hex_b[5], hex_b[4], hex_b[3], hex_b[2], hex_b[1], hex_b[0]});
        end else begin
            if (plot_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_plot", 1, 0);
                end else begin
                    e = qb.pop_front();
                    check_plot("b", e, cyc - last_b, x_b, y_b, col_b, ledr_b, {r_b, g_b, bl_b},
                               {hs_b, vs_b, vclk_b},
                               {hex_b[5], hex_b[4], hex_b[3], hex_b[2], hex_b[1], hex_b[0]});
                    if (e.x == 7 && e.y == 5) check("b_inside_set_colour", col_b, 0);
                end
                last_b = cyc;
                plots_b++;
            end
            if (ledr_b[3] && !done_seen_b) begin
                done_seen_b = 1'b1;
                check("b_done_after_last_plot", plots_b, B_W * B_H);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int target;
        int base;
        bit hit;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat ($urandom_range(8, 3)) @(negedge clk);
        #2;
        rst_a = 1'b1;
        rst_b = 1'b1;
        last_a = cyc - 1;
        last_b = cyc - 1;
        push_frame(1'b0);
        push_frame(1'b1);

        // Abort frame A mid-strobe, somewhere past the first row wrap
        target = $urandom_range(330, 170);
        hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (plots_a >= target && plot_a) begin
                hit = 1'b1;
                break;
            end
        end
        check("a_reach_abort_point", hit, 1);
        #1;
        rst_a = 1'b0;
        #1;
        check("a_async_plot_clear", plot_a, 0);
        check("a_async_ledr_clear", ledr_a, 0);
        check("a_async_xy_clear", {x_a, y_a}, 0);
        check("a_async_colour_clear", col_a, 0);
        qa.delete();
        repeat ($urandom_range(5, 2)) @(negedge clk);
        #2;
        rst_a = 1'b1;
        last_a = cyc - 1;
        push_frame(1'b0);
        base = plots_a;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (plots_a >= base + 3) begin
                hit = 1'b1;
                break;
            end
        end
        check("a_restart_plots", hit, 1);

        hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            #1;
            if (ledr_b[3]) begin
                hit = 1'b1;
                break;
            end
        end
        check("b_done_reached", hit, 1);
        check("b_plot_count", plots_b, B_W * B_H);
        check("b_queue_drained", qb.size(), 0);
        check("b_done_ledr", ledr_b, 10'b00_0000_1000);
        repeat (60) @(negedge clk);
        #1;
        check("b_no_plots_after_done", plots_b, B_W * B_H);
        check("b_done_ledr_held", ledr_b, 10'b00_0000_1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
